// File: rtl/addsub_parity_pipe.sv
// addsub_parity_pipe
// Two-stage add/subtract unit with result parity ("balance") and status flags.
// Stage 1 holds the raw WIDTH-bit result plus carry/borrow and overflow;
// stage 2 is the output register set that drives the shared result bus.
// Both stages use valid/ready handshaking with full backpressure.
module addsub_parity_pipe #(
    parameter int WIDTH     = 5,
    parameter int OUT_WIDTH = 32,
    parameter bit SIGN_EXT  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op,
    input  logic [WIDTH-1:0]     number1,
    input  logic [WIDTH-1:0]     number2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] output_result,
    output logic                 balance,
    output logic                 carry_borrow,
    output logic                 overflow,
    output logic                 zero
);

    // stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_raw_q;
    logic             s1_cb_q;
    logic             s1_ov_q;

    // output stage state
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] res_q;
    logic                 bal_q;
    logic                 cb_q;
    logic                 ov_q;
    logic                 zero_q;

    // handshake
    logic accept;
    logic adv2;

    // stage 1 next values
    logic [WIDTH:0]   wide_d;
    logic [WIDTH-1:0] raw_d;
    logic             cb_d;
    logic             ov_d;

    // stage 2 next values
    logic [OUT_WIDTH-1:0] ext_d;

    // Handshake: s1 can take a beat when it is empty or will drain this cycle.
    always_comb begin
        adv2     = s1_valid_q & (~out_valid_q | out_ready);
        in_ready = ~s1_valid_q | ~out_valid_q | out_ready;
        accept   = in_valid & in_ready;

        s1_valid_d  = accept | (s1_valid_q & ~adv2);
        out_valid_d = adv2 | (out_valid_q & ~out_ready);
    end

    // Arithmetic at WIDTH+1 bits; the top bit is carry on add and borrow on sub.
    always_comb begin
        if (op) begin
            wide_d = {1'b0, number1} - {1'b0, number2};
        end else begin
            wide_d = {1'b0, number1} + {1'b0, number2};
        end
        raw_d = wide_d[WIDTH-1:0];
        cb_d  = wide_d[WIDTH];

        if (op) begin
            ov_d = (number1[WIDTH-1] != number2[WIDTH-1]) &&
                   (raw_d[WIDTH-1] != number1[WIDTH-1]);
        end else begin
            ov_d = (number1[WIDTH-1] == number2[WIDTH-1]) &&
                   (raw_d[WIDTH-1] != number1[WIDTH-1]);
        end
    end

    // Extend the stage-1 raw result onto the output bus width.
    // Written as fill-then-overlay so OUT_WIDTH == WIDTH needs no special case.
    always_comb begin
        if (SIGN_EXT && s1_raw_q[WIDTH-1]) begin
            ext_d = '1;
        end else begin
            ext_d = '0;
        end
        ext_d[WIDTH-1:0] = s1_raw_q;
    end

    // Stage 1 register: loads on accept, valid tracks fill/drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_raw_q   <= '0;
            s1_cb_q    <= 1'b0;
            s1_ov_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_raw_q <= raw_d;
                s1_cb_q  <= cb_d;
                s1_ov_q  <= ov_d;
            end
        end
    end

    // Output register: loads when s1 advances, otherwise holds (stable under stall).
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            bal_q       <= 1'b0;
            cb_q        <= 1'b0;
            ov_q        <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (adv2) begin
                res_q  <= ext_d;
                bal_q  <= ~^s1_raw_q;
                cb_q   <= s1_cb_q;
                ov_q   <= s1_ov_q;
                zero_q <= (s1_raw_q == '0);
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign output_result = res_q;
    assign balance       = bal_q;
    assign carry_borrow  = cb_q;
    assign overflow      = ov_q;
    assign zero          = zero_q;

endmodule

// File: tb/tb_addsub_parity_pipe.sv
// Testbench for addsub_parity_pipe (WIDTH=5, OUT_WIDTH=32).
// A sign-extending and a zero-extending instance share stimulus; a scoreboard
// queue holds expected results pushed on accept and popped on output handshake.
module tb_addsub_parity_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [4:0]  number1;
    logic [4:0]  number2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] output_result;
    logic        balance;
    logic        carry_borrow;
    logic        overflow;
    logic        zero;

    logic        z_in_ready;
    logic        z_out_valid;
    logic [31:0] z_output_result;
    logic        z_balance;
    logic        z_carry_borrow;
    logic        z_overflow;
    logic        z_zero;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  raw;
        logic        bal;
        logic        cb;
        logic        ov;
        logic        zr;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   rnd_done;

    addsub_parity_pipe #(.WIDTH(5), .OUT_WIDTH(32), .SIGN_EXT(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .number1(number1), .number2(number2),
        .out_valid(out_valid), .out_ready(out_ready),
        .output_result(output_result), .balance(balance),
        .carry_borrow(carry_borrow), .overflow(overflow), .zero(zero)
    );

    addsub_parity_pipe #(.WIDTH(5), .OUT_WIDTH(32), .SIGN_EXT(1'b0)) u_dut_z (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(z_in_ready),
        .op(op), .number1(number1), .number2(number2),
        .out_valid(z_out_valid), .out_ready(out_ready),
        .output_result(z_output_result), .balance(z_balance),
        .carry_borrow(z_carry_borrow), .overflow(z_overflow), .zero(z_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model built from integer arithmetic.
    function automatic exp_t model(input logic o, input logic [4:0] a, input logic [4:0] b);
        exp_t e;
        int ai, bi, sa, sb, r, sr, pc;
        ai = int'(a);
        bi = int'(b);
        sa = a[4] ? ai - 32 : ai;
        sb = b[4] ? bi - 32 : bi;
        r  = o ? ai - bi : ai + bi;
        sr = o ? sa - sb : sa + sb;
        e.raw = 5'((r + 64) % 32);
        e.cb  = o ? (ai < bi) : (r > 31);
        e.ov  = (sr > 15) || (sr < -16);
        pc = 0;
        for (int i = 0; i < 5; i++) pc += int'(e.raw[i]);
        e.bal = (pc % 2) == 0;
        e.zr  = (e.raw == 5'd0);
        e.res = e.raw[4] ? {27'h7FF_FFFF, e.raw} : {27'd0, e.raw};
        return e;
    endfunction

    // Scoreboard: observe handshakes half a cycle before the edge that commits them.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("result",       output_result,          e.res);
                    chk("balance",      {31'd0, balance},       {31'd0, e.bal});
                    chk("carry_borrow", {31'd0, carry_borrow},  {31'd0, e.cb});
                    chk("overflow",     {31'd0, overflow},      {31'd0, e.ov});
                    chk("zero",         {31'd0, zero},          {31'd0, e.zr});
                    chk("zext_result",  z_output_result,        {27'd0, e.raw});
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(op, number1, number2));
            end
        end
    end

    task automatic send(input logic o, input logic [4:0] a, input logic [4:0] b);
        int w;
        w = 0;
        in_valid = 1'b1;
        op       = o;
        number1  = a;
        number2  = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 50) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb_q.size() != 0 || out_valid) && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_timeout", {31'd0, (w >= 100)}, 32'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid},    32'd0);
        chk({tag, "_in_ready"},  {31'd0, in_ready},     32'd1);
        chk({tag, "_result"},    output_result,         32'd0);
        chk({tag, "_flags"},     {28'd0, balance, carry_borrow, overflow, zero}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held;

        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 1'b0;
        number1   = '0;
        number2   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Sub 3-5: not visible after the accepting edge, visible after the next.
        send(1'b1, 5'd3, 5'd5);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid",  {31'd0, out_valid},    32'd1);
        chk("sub35_res",  output_result,         32'hFFFF_FFFE);
        chk("sub35_bal",  {31'd0, balance},      32'd1);
        chk("sub35_cb",   {31'd0, carry_borrow}, 32'd1);
        chk("sub35_ov",   {31'd0, overflow},     32'd0);
        chk("sub35_zero", {31'd0, zero},         32'd0);
        drain();

        // Back-to-back directed beats.
        send(1'b1, 5'd31, 5'd0);
        send(1'b0, 5'd15, 5'd1);
        send(1'b1, 5'd7,  5'd7);
        @(posedge clk);
        #1;
        chk("sub77_res",  output_result,     32'd0);
        chk("sub77_zero", {31'd0, zero},     32'd1);
        chk("sub77_bal",  {31'd0, balance},  32'd1);
        drain();

        // Backpressure: 4 beats offered with the consumer stalled.
        out_ready = 1'b0;
        rnd_done  = 1'b0;
        fork
            begin
                send(1'b0, 5'd1,  5'd2);
                send(1'b1, 5'd9,  5'd20);
                send(1'b0, 5'd16, 5'd16);
                send(1'b1, 5'd0,  5'd1);
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_accepted",  sb_q.size(),        32'd2);
                held = output_result;
                repeat (3) begin
                    @(posedge clk);
                    #2;
                    chk("bp_hold_res",   output_result,      held);
                    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight.
        send(1'b0, 5'd1, 5'd2);
        send(1'b0, 5'd3, 5'd4);
        chk("rst_inflight", sb_q.size(), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_idle_outputs("midrst");
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("no_stale", {31'd0, out_valid}, 32'd0);
        end

        // Random traffic with random backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                         5'($urandom_range(0, 31)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #2;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
